// File: rtl/daq_frame_trailer_pkg.sv
// daq_pkg: shared FSM state type and CRC-16/CCITT helper for the frame trailer.
package daq_pkg;
    typedef enum logic [1:0] {IDLE, PASS, CRC, CNT} state_t;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    // MSB-first, one full 16-bit word per call, no reflection or final XOR
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/daq_frame_trailer_if.sv
// daq_frame_trailer_if: sequencer word stream in, serializer word stream and status out.
interface daq_frame_trailer_if;
    logic [15:0] DIN;
    logic        VALID;
    logic        CLR_CRC;
    logic        LAST_WRD;
    logic [15:0] DOUT;
    logic        DOUT_VLD;
    logic        DOUT_SOF;
    logic        DOUT_EOF;
    logic [11:0] FRM_CNT;
    logic        OVF_ERR;
    logic        FRM_ERR;
    modport master (output DIN, VALID, CLR_CRC, LAST_WRD,
                    input DOUT, DOUT_VLD, DOUT_SOF, DOUT_EOF, FRM_CNT, OVF_ERR, FRM_ERR);
    modport slave (input DIN, VALID, CLR_CRC, LAST_WRD,
                   output DOUT, DOUT_VLD, DOUT_SOF, DOUT_EOF, FRM_CNT, OVF_ERR, FRM_ERR);
endinterface

// File: rtl/daq_frame_trailer_fifo.sv
// daq_sync_fifo: single-clock FIFO; a write while full is accepted only when a pop frees a slot.
module daq_sync_fifo #(
    parameter int AW = 2,
    parameter int W  = 18
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_i,
    input  logic         rd_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         ovf_o
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;
    assign full_o  = cnt_q[AW];
    assign empty_o = cnt_q == '0;
    assign push    = wr_i & (~full_o | rd_i);
    assign pop     = rd_i & ~empty_o;
    assign ovf_o   = wr_i & full_o & ~rd_i;
    assign rdata_o = mem[rptr_q];
    assign cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= wdata_i;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
            rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/daq_frame_trailer.sv
// daq_frame_trailer: buffers sequencer frames, recomputes CRC-16 and appends CRC + frame-count trailer words.
module daq_frame_trailer
    import daq_pkg::*;
#(
    parameter int          FIFO_AW = 2,
    parameter logic [3:0]  TRL_ID  = 4'hE
) (
    input logic CLK,
    input logic RST,
    daq_frame_trailer_if.slave bus
);
    logic [17:0] rdata;
    logic        full, empty, ovf, rd;
    logic        first, last;
    logic [15:0] word;
    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d, dout_q, dout_d;
    logic        vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
    logic [11:0] cnt_q, cnt_d;
    logic        ovf_q, frm_err_q, frm_err_d;
    daq_sync_fifo #(.AW(FIFO_AW), .W(18)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .wr_i    (bus.VALID),
        .rd_i    (rd),
        .wdata_i ({bus.CLR_CRC, bus.LAST_WRD, bus.DIN}),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .ovf_o   (ovf)
    );
    assign {first, last, word} = rdata;
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        dout_d    = dout_q;
        vld_d     = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        cnt_d     = cnt_q;
        frm_err_d = frm_err_q;
        rd        = 1'b0;
        case (state_q)
            IDLE, PASS: if (!empty) begin
                rd = 1'b1;
                // a stray word between frames is dropped; a restart inside a frame abandons the old one
                if (state_q == IDLE && !first) frm_err_d = 1'b1;
                else begin
                    dout_d    = word;
                    vld_d     = 1'b1;
                    sof_d     = first;
                    crc_d     = crc16_word(first ? CRC_INIT : crc_q, word);
                    frm_err_d = frm_err_q | (state_q == PASS && first);
                    state_d   = last ? CRC : PASS;
                end
            end
            CRC: begin
                dout_d  = crc_q;
                vld_d   = 1'b1;
                state_d = CNT;
            end
            default: begin
                dout_d  = {TRL_ID, cnt_q + 12'd1};
                vld_d   = 1'b1;
                eof_d   = 1'b1;
                cnt_d   = cnt_q + 12'd1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_q | ovf;
            frm_err_q <= frm_err_d;
        end
    end
    assign bus.DOUT     = dout_q;
    assign bus.DOUT_VLD = vld_q;
    assign bus.DOUT_SOF = sof_q;
    assign bus.DOUT_EOF = eof_q;
    assign bus.FRM_CNT  = cnt_q;
    assign bus.OVF_ERR  = ovf_q;
    assign bus.FRM_ERR  = frm_err_q;
    wire unused_full = full;
endmodule

// File: tb/tb_daq_frame_trailer.sv
// tb_daq_frame_trailer: directed scenarios for the frame trailer, default FIFO and a 2-deep FIFO variant.
module tb_daq_frame_trailer;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int failures = 0;
    int vld1_n = 0;
    logic [17:0] oq[$];
    logic [17:0] exp_q[$];
    daq_frame_trailer_if b0 ();
    daq_frame_trailer_if b1 ();
    daq_frame_trailer #(.FIFO_AW(2), .TRL_ID(4'hE)) dut0 (.CLK(clk), .RST(RST), .bus(b0));
    daq_frame_trailer #(.FIFO_AW(1), .TRL_ID(4'hE)) dut1 (.CLK(clk), .RST(RST), .bus(b1));
    assign b1.DIN      = b0.DIN;
    assign b1.VALID    = b0.VALID;
    assign b1.CLR_CRC  = b0.CLR_CRC;
    assign b1.LAST_WRD = b0.LAST_WRD;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (b0.DOUT_VLD) oq.push_back({b0.DOUT_SOF, b0.DOUT_EOF, b0.DOUT});
        if (b1.DOUT_VLD) vld1_n++;
    end
    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [15:0] d);
        for (int i = 15; i >= 0; i--) c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction
    task automatic send(input logic [15:0] w, input logic f, input logic l);
        b0.DIN = w; b0.VALID = 1'b1; b0.CLR_CRC = f; b0.LAST_WRD = l;
        @(posedge clk); #1;
    endtask
    task automatic idle(input int n);
        b0.VALID = 1'b0; b0.CLR_CRC = 1'b0; b0.LAST_WRD = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic do_reset();
        idle(0);
        RST = 1'b1;
        @(posedge clk); #1;
        oq.delete(); exp_q.delete(); vld1_n = 0;
        RST = 1'b0;
        idle(1);
    endtask
    task automatic test_reset();
        idle(0);
        RST = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (b0.DOUT !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", b0.DOUT); end
        checks++; if ({b0.DOUT_VLD, b0.DOUT_SOF, b0.DOUT_EOF} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {b0.DOUT_VLD, b0.DOUT_SOF, b0.DOUT_EOF}); end
        checks++; if (b0.FRM_CNT !== 12'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=000", b0.FRM_CNT); end
        checks++; if ({b0.OVF_ERR, b0.FRM_ERR} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {b0.OVF_ERR, b0.FRM_ERR}); end
        @(posedge clk); #1;
        RST = 1'b0;
        idle(1);
    endtask
    task automatic test_single_word();
        logic [16:0] exp_seq [5];
        logic [3:0]  se      [5];
        exp_seq = '{17'h0_0000, 17'h1_0000, 17'h1_1D0F, 17'h1_E001, 17'h0_0000};
        se      = '{4'h0, 4'h2, 4'h0, 4'h1, 4'h0};
        do_reset();
        send(16'h0000, 1'b1, 1'b1);
        idle(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (b0.DOUT_VLD !== exp_seq[i][16] || (exp_seq[i][16] && b0.DOUT !== exp_seq[i][15:0])) begin
                failures++; $display("FAIL single_cyc%0d got vld=%b dout=%h exp vld=%b dout=%h", i, b0.DOUT_VLD, b0.DOUT, exp_seq[i][16], exp_seq[i][15:0]);
            end
            checks++;
            if ({b0.DOUT_SOF, b0.DOUT_EOF} !== se[i][1:0]) begin
                failures++; $display("FAIL single_sofeof%0d got=%b exp=%b", i, {b0.DOUT_SOF, b0.DOUT_EOF}, se[i][1:0]);
            end
        end
        checks++; if (b0.FRM_CNT !== 12'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", b0.FRM_CNT); end
    endtask
    task automatic test_eight_word();
        logic [15:0] c;
        do_reset();
        c = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            send(16'(i), i == 0, i == 7);
            c = m_crc(c, 16'(i));
            exp_q.push_back({i == 0, 1'b0, 16'(i)});
        end
        exp_q.push_back({2'b00, c});
        exp_q.push_back({2'b01, 16'hE001});
        idle(15);
        checks++; if (oq.size() != exp_q.size()) begin failures++; $display("FAIL eight_len got=%0d exp=%0d", oq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < oq.size(); i++) begin
            checks++; if (oq[i] !== exp_q[i]) begin failures++; $display("FAIL eight_word%0d got=%h exp=%h", i, oq[i], exp_q[i]); end
        end
        checks++; if ({b0.OVF_ERR, b0.FRM_ERR} !== 2'b00) begin failures++; $display("FAIL eight_err got=%b exp=00", {b0.OVF_ERR, b0.FRM_ERR}); end
    endtask
    task automatic test_two_frames();
        logic [15:0] fa [3];
        logic [15:0] fb [4];
        logic [15:0] c;
        fa = '{16'h1111, 16'h2222, 16'h3333};
        fb = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001};
        do_reset();
        c = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            send(fa[i], i == 0, i == 2); c = m_crc(c, fa[i]); exp_q.push_back({i == 0, 1'b0, fa[i]});
        end
        exp_q.push_back({2'b00, c}); exp_q.push_back({2'b01, 16'hE001});
        idle(2);
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            send(fb[i], i == 0, i == 3); c = m_crc(c, fb[i]); exp_q.push_back({i == 0, 1'b0, fb[i]});
        end
        exp_q.push_back({2'b00, c}); exp_q.push_back({2'b01, 16'hE002});
        idle(15);
        checks++; if (oq.size() != exp_q.size()) begin failures++; $display("FAIL two_len got=%0d exp=%0d", oq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < oq.size(); i++) begin
            checks++; if (oq[i] !== exp_q[i]) begin failures++; $display("FAIL two_word%0d got=%h exp=%h", i, oq[i], exp_q[i]); end
        end
        checks++; if (b0.OVF_ERR !== 1'b0) begin failures++; $display("FAIL two_ovf got=%b exp=0", b0.OVF_ERR); end
        checks++; if (b0.FRM_CNT !== 12'd2) begin failures++; $display("FAIL two_cnt got=%0d exp=2", b0.FRM_CNT); end
    endtask
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 12; i++) send(16'h0100 + 16'(i), i % 4 == 0, i % 4 == 3);
        idle(20);
        checks++; if (b1.OVF_ERR !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", b1.OVF_ERR); end
        checks++; if (vld1_n >= 18) begin failures++; $display("FAIL ovf_drop got=%0d words exp=<18", vld1_n); end
        idle(5);
        checks++; if (b1.OVF_ERR !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", b1.OVF_ERR); end
        RST = 1'b1; #1;
        checks++; if (b1.OVF_ERR !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", b1.OVF_ERR); end
        @(posedge clk); #1;
        RST = 1'b0;
        idle(1);
    endtask
    task automatic test_frame_error();
        logic [15:0] w [5];
        logic [15:0] c;
        w = '{16'hC001, 16'hC002, 16'hD003, 16'hD004, 16'hD005};
        do_reset();
        c = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            send(w[i], i == 0 || i == 2, i == 4);
            if (i >= 2) c = m_crc(c, w[i]);
            exp_q.push_back({i == 0 || i == 2, 1'b0, w[i]});
        end
        exp_q.push_back({2'b00, c}); exp_q.push_back({2'b01, 16'hE001});
        idle(15);
        checks++; if (b0.FRM_ERR !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", b0.FRM_ERR); end
        checks++; if (oq.size() != exp_q.size()) begin failures++; $display("FAIL ferr_len got=%0d exp=%0d", oq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < oq.size(); i++) begin
            checks++; if (oq[i] !== exp_q[i]) begin failures++; $display("FAIL ferr_word%0d got=%h exp=%h", i, oq[i], exp_q[i]); end
        end
    endtask
    task automatic test_mid_reset();
        logic [15:0] c;
        do_reset();
        for (int i = 0; i < 4; i++) send(16'h0010 + 16'(i), i == 0, 1'b0);
        idle(0);
        RST = 1'b1; #1;
        checks++; if ({b0.DOUT, b0.DOUT_VLD, b0.DOUT_SOF, b0.DOUT_EOF} !== 19'h0) begin failures++; $display("FAIL mrst_out got=%h/%b%b%b exp=0", b0.DOUT, b0.DOUT_VLD, b0.DOUT_SOF, b0.DOUT_EOF); end
        checks++; if ({b0.FRM_CNT, b0.OVF_ERR, b0.FRM_ERR} !== 14'h0) begin failures++; $display("FAIL mrst_stat got=%h exp=0", {b0.FRM_CNT, b0.OVF_ERR, b0.FRM_ERR}); end
        @(posedge clk); #1;
        RST = 1'b0;
        oq.delete();
        c = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            send(16'h0020 + 16'(i), i == 0, i == 7);
            c = m_crc(c, 16'h0020 + 16'(i));
            exp_q.push_back({i == 0, 1'b0, 16'h0020 + 16'(i)});
        end
        exp_q.push_back({2'b00, c}); exp_q.push_back({2'b01, 16'hE001});
        idle(15);
        checks++; if (oq.size() != exp_q.size()) begin failures++; $display("FAIL mrst_len got=%0d exp=%0d", oq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < oq.size(); i++) begin
            checks++; if (oq[i] !== exp_q[i]) begin failures++; $display("FAIL mrst_word%0d got=%h exp=%h", i, oq[i], exp_q[i]); end
        end
    endtask
    initial begin
        b0.DIN = '0; b0.VALID = 1'b0; b0.CLR_CRC = 1'b0; b0.LAST_WRD = 1'b0;
        test_reset();
        test_single_word();
        test_eight_word();
        test_two_frames();
        test_overflow();
        test_frame_error();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
